dma_master: RTL and testbench
=============================

# dma_master

Bus master that copies a block of 32-bit words from one bus address range to another, one word at a time. It connects to the shared bus's second master port (M1_*) and competes with the CPU-side master through the bus arbitrator. Each transfer is a read from the source address followed by a write to the destination address. Read data arrives on the bus one cycle after the address because the bus registers the slave select.

## Interface
- ADDR_W, 8, bus address width
- DATA_W, 32, bus data width
- LEN_W, 8, transfer-length counter width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- length  in  LEN_W  number of words to copy
- M_grant  in  1  bus grant from arbitrator
- M_din  in  DATA_W  read data from bus, valid the cycle after a read address
- M_req  out  1  bus request
- M_wr  out  1  1 = write, 0 = read
- M_address  out  ADDR_W  bus address
- M_dout  out  DATA_W  write data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse on completion

## Operation
- Reset: state IDLE. M_req, M_wr, M_address, M_dout, busy and done are all 0. Internal address, count and data registers are cleared.
- IDLE:
  - start=1 with length≠0 latches src_addr, dst_addr and length, sets busy and goes to REQ.
  - start=1 with length=0 pulses done in the next cycle and produces no bus activity.
- REQ: M_req=1. On M_grant=1 go to READ; otherwise stay.
- READ: M_req=1, M_wr=0, M_address=src. Go to CAPTURE.
- CAPTURE: M_req=1, M_wr=0, M_address=src (held). Register M_din into data_reg at the end of the cycle. Go to WRITE.
- WRITE: M_req=1, M_wr=1, M_address=dst, M_dout=data_reg. Then:
  - increment src and dst (each wraps 8'hFF→8'h00);
  - decrement count;
  - if count was 1, go to DONE; else go to READ.
- DONE: done=1 for exactly one cycle. busy and M_req drop to 0 in the same cycle. Return to IDLE.
- Grant loss: if M_grant=0 during READ, CAPTURE or WRITE, that word is abandoned. Go to REQ with src, dst and count unchanged; the word is retried from READ after the next grant. A partially completed word is never counted.
- Outside READ, CAPTURE and WRITE, M_wr=0, M_address=0 and M_dout=0.
- start while busy is ignored. Input changes after latching have no effect.
- Reset asserted mid-transfer aborts immediately: IDLE, all outputs 0, no done pulse.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Start to first M_req: 1 cycle.
- Per word, with continuous grant: 3 cycles (READ, CAPTURE, WRITE).
- N-word transfer with immediate grant: start at cycle 0, M_req from cycle 1, READ at cycle 2, done at cycle 2+3N.
- M_req stays asserted continuously from REQ to the last WRITE inclusive.
- busy falls in the same cycle done rises.
- A new start is accepted in the cycle after done.

## Structure
- Package dma_pkg:
  - state encoding localparams IDLE, REQ, READ, CAPTURE, WRITE, DONE (3 bits);
  - default width constants ADDR_W, DATA_W, LEN_W.
- Single module; no sub-module needed. The next-state logic and the output decode are separate processes within it.

## Test plan
- Reset, then start with src=8'h00, dst=8'h40, length=4, slave data words 32'h11,22,33,44, grant always high:
  - writes to 8'h40..8'h43 carry 32'h11..44 in order;
  - done pulses at cycle 14;
  - busy is high for cycles 1–13.
- length=0 with start -> done pulses at cycle 1; M_req never asserts.
- src=8'hFE, dst=8'hFF, length=3 -> reads from FE, FF, 00; writes to FF, 00, 01 (wrap-around).
- Hold M_grant low for 5 cycles after the request, then drop it in CAPTURE of word 2 -> word 2 is re-read from the same src after re-grant; exactly length writes occur and destination data is correct.
- Assert reset during the WRITE of word 3 of 8 -> all outputs are 0 on the next edge; no done pulse; a fresh start after reset runs normally.
- Pulse start again while busy with different addresses -> the second start is ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the word-copy DMA master.
package dma_pkg;

  // Default bus and counter widths.
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  // Raw 3-bit state codes.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  typedef enum logic [2:0] {
    StIdle    = IDLE,
    StReq     = REQ,
    StRead    = READ,
    StCapture = CAPTURE,
    StWrite   = WRITE,
    StDone    = DONE
  } state_e;

endpackage

// File: rtl/dma_master.sv
// Bus master copying a block of words: read src, capture data, write dst, repeat.
// All outputs are decoded from registered state, never from inputs.
module dma_master
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = dma_pkg::ADDR_W,
  parameter int unsigned DATA_W = dma_pkg::DATA_W,
  parameter int unsigned LEN_W  = dma_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state: sequence one word at a time; any grant loss abandons the word.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            cnt_d   = length;
            state_d = StReq;
          end else begin
            // Zero-length request completes without touching the bus.
            state_d = StDone;
          end
        end
      end
      StReq: begin
        if (M_grant) state_d = StRead;
      end
      StRead: begin
        state_d = M_grant ? StCapture : StReq;
      end
      StCapture: begin
        if (M_grant) begin
          data_d  = M_din;
          state_d = StWrite;
        end else begin
          state_d = StReq;
        end
      end
      StWrite: begin
        if (M_grant) begin
          // Word committed: advance pointers (natural wrap) and count.
          src_d   = src_q + ADDR_W'(1);
          dst_d   = dst_q + ADDR_W'(1);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? StDone : StRead;
        end else begin
          state_d = StReq;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Output decode from state and registers only.
  always_comb begin
    M_req     = 1'b0;
    M_wr      = 1'b0;
    M_address = '0;
    M_dout    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StReq: begin
        M_req = 1'b1;
        busy  = 1'b1;
      end
      StRead, StCapture: begin
        M_req     = 1'b1;
        busy      = 1'b1;
        M_address = src_q;
      end
      StWrite: begin
        M_req     = 1'b1;
        busy      = 1'b1;
        M_wr      = 1'b1;
        M_address = dst_q;
        M_dout    = data_q;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        M_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_master.sv
// Directed bench for dma_master with a registered-read slave and a write scoreboard.
module tb_dma_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [7:0]  length = '0;
  logic        M_grant = 1'b1;
  logic [31:0] M_din = '0;
  logic        M_req;
  logic        M_wr;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic        busy;
  logic        done;

  dma_master dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .M_grant  (M_grant),
    .M_din    (M_din),
    .M_req    (M_req),
    .M_wr     (M_wr),
    .M_address(M_address),
    .M_dout   (M_dout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Slave memory; read data is registered, so it follows the address by one cycle.
  logic [31:0] mem [256];
  always @(posedge clk) M_din <= mem[M_address];

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every granted write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && M_req && M_grant && M_wr) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL extra_write: observed addr %0h data %0h expected no write", M_address,
               M_dout);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(M_address), 64'(mon_e.a));
        check("write_data", 64'(M_dout), 64'(mon_e.d));
      end
    end
  end

  // One transfer: start in cycle 0, then observe cycles 1..40 until done.
  // Grant is low in cycles lo_a..lo_b and lo_c; restart_cyc re-pulses start;
  // rst_cyc asserts reset for two cycles. Only the first nexp words are expected.
  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                     input int nexp, input int lo_a, input int lo_b, input int lo_c,
                     input int restart_cyc, input int rst_cyc,
                     output int done_cyc, output int done_n, output int busy_first,
                     output int busy_last, output int busy_n, output int req_n);
    wr_t        e;
    logic [7:0] sa, da;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(l) && i < nexp; i++) begin
      sa  = s + 8'(i);
      da  = d + 8'(i);
      e.a = da;
      e.d = mem[sa];
      exp_q.push_back(e);
    end
    start      = 1'b1;
    src_addr   = s;
    dst_addr   = d;
    length     = l;
    M_grant    = 1'b1;
    done_cyc   = -1;
    done_n     = 0;
    busy_first = -1;
    busy_last  = -1;
    busy_n     = 0;
    req_n      = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        src_addr = 8'h80;
        dst_addr = 8'h90;
        length   = 8'd5;
      end else if (c == 1) begin
        // Latched values must not follow the inputs.
        src_addr = ~s;
        dst_addr = ~d;
        length   = l + 8'd3;
      end
      M_grant = !((c >= lo_a && c <= lo_b) || c == lo_c);
      if (c == rst_cyc) reset = 1'b1;
      if (c == rst_cyc + 2) reset = 1'b0;
      @(negedge clk);
      if (c == rst_cyc) begin
        check("reset_abort_outputs", 64'({M_req, M_wr, busy, done, M_address, M_dout}), 64'd0);
      end
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        busy_n++;
      end
      if (M_req) req_n++;
      if (done) begin
        done_n++;
        done_cyc = c;
        check("done_cycle_outputs", 64'({busy, M_req, M_wr, M_address, M_dout}), 64'd0);
        break;
      end
    end
    start = 1'b0;
  endtask

  int dc, dn, bf, bl, bn, rn;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {8'hD0, 8'(a), 8'h5A, 8'(a)};
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({M_req, M_wr, busy, done, M_address, M_dout}), 64'd0);
    reset = 1'b0;

    // Basic 4-word copy, grant always high: done at 2+3*4.
    run(8'h00, 8'h40, 8'd4, 99, -1, -1, -1, -1, -1, dc, dn, bf, bl, bn, rn);
    check("t1_done_cycle", 64'(dc), 64'(14));
    check("t1_done_count", 64'(dn), 64'(1));
    check("t1_busy_first", 64'(bf), 64'(1));
    check("t1_busy_last", 64'(bl), 64'(13));
    check("t1_busy_cycles", 64'(bn), 64'(13));
    check("t1_req_cycles", 64'(rn), 64'(13));
    check("t1_writes_done", 64'(exp_q.size()), 64'(0));

    // Zero length: done in cycle 1, no request.
    run(8'h10, 8'h20, 8'd0, 99, -1, -1, -1, -1, -1, dc, dn, bf, bl, bn, rn);
    check("t2_done_cycle", 64'(dc), 64'(1));
    check("t2_req_cycles", 64'(rn), 64'(0));
    check("t2_busy_cycles", 64'(bn), 64'(0));

    // Address wrap on both pointers.
    run(8'hFE, 8'hFF, 8'd3, 99, -1, -1, -1, -1, -1, dc, dn, bf, bl, bn, rn);
    check("t3_done_cycle", 64'(dc), 64'(11));
    check("t3_writes_done", 64'(exp_q.size()), 64'(0));

    // Grant low in REQ cycles 1..5 (READ at 7), then lost in CAPTURE of word 2
    // (cycle 11). Re-grant in REQ at 12, word 2 again 13..15, word 3 16..18, done 19.
    run(8'h10, 8'h20, 8'd3, 99, 1, 5, 11, -1, -1, dc, dn, bf, bl, bn, rn);
    check("t4_done_cycle", 64'(dc), 64'(19));
    check("t4_req_cycles", 64'(rn), 64'(18));
    check("t4_busy_cycles", 64'(bn), 64'(18));
    check("t4_writes_done", 64'(exp_q.size()), 64'(0));

    // Second start while busy is ignored.
    run(8'h30, 8'h50, 8'd3, 99, -1, -1, -1, 4, -1, dc, dn, bf, bl, bn, rn);
    check("t5_done_cycle", 64'(dc), 64'(11));
    check("t5_writes_done", 64'(exp_q.size()), 64'(0));

    // Reset during WRITE of word 3 of 8 (cycle 10): only words 1-2 land, no done.
    run(8'h60, 8'h70, 8'd8, 2, -1, -1, -1, -1, 10, dc, dn, bf, bl, bn, rn);
    check("t6_done_count", 64'(dn), 64'(0));
    check("t6_busy_last", 64'(bl), 64'(9));
    check("t6_writes_done", 64'(exp_q.size()), 64'(0));

    // Fresh transfer after reset behaves normally.
    run(8'h04, 8'hC0, 8'd2, 99, -1, -1, -1, -1, -1, dc, dn, bf, bl, bn, rn);
    check("t7_done_cycle", 64'(dc), 64'(8));
    check("t7_busy_cycles", 64'(bn), 64'(7));
    check("t7_writes_done", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
